// File: rtl/ama_riscv_encoder.sv
// RV32IM instruction encoder: turns field-level requests into 32-bit words,
// expands LI into LUI/ADDI, and buffers words in an output FIFO drained by
// a valid/ready handshake.
// Optional feature macro: ENC_RANGE_CHECK_EN (immediate range checking with
// sticky err flag and saturating err_cnt). Without it, immediates are
// truncated, err/err_cnt read 0, and illegal ops emit a NOP.
module ama_riscv_encoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [2:0]       req_fn3,
  input  logic             req_fn7_b5,
  input  logic             req_fn7_b0,
  input  logic [4:0]       req_rd,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [31:0]      req_imm,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_FW = PTR_W + 1;
  localparam int unsigned WORD_W = 32;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_LI_LO = 1'b1;

  localparam logic [3:0] OP_R      = 4'd0;
  localparam logic [3:0] OP_I      = 4'd1;
  localparam logic [3:0] OP_LOAD   = 4'd2;
  localparam logic [3:0] OP_STORE  = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4;
  localparam logic [3:0] OP_JALR   = 4'd5;
  localparam logic [3:0] OP_JAL    = 4'd6;
  localparam logic [3:0] OP_LUI    = 4'd7;
  localparam logic [3:0] OP_AUIPC  = 4'd8;
  localparam logic [3:0] OP_LI     = 4'd9;

  localparam logic [6:0] OPC_R      = 7'h33;
  localparam logic [6:0] OPC_I      = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;

  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0013;

  logic [0:0]        state_q, state_d;
  logic [WORD_W-1:0] li_word_q, li_word_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic              full_q, full_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] inst_q, inst_d;
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];

  logic              accept_c;
  logic              push_c, pop_c;
  logic [WORD_W-1:0] push_word_c, head_c;
  logic [WORD_W-1:0] enc_word_c, li_lo_word_c;
  logic [19:0]       li_hi_c;
  logic              li_two_c;
  logic              is_shift_c, imm_fits12_c;
  logic              range_err_c;

  assign accept_c     = req_valid && ready_q;
  assign is_shift_c   = (req_fn3 == 3'b001) || (req_fn3 == 3'b101);
  assign imm_fits12_c = (&req_imm[31:11]) || !(|req_imm[31:11]);

  assign req_ready  = ready_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;

  // Field packing per op class; unused fields are zero by construction
  always_comb begin
    enc_word_c   = NOP_WORD;
    li_two_c     = 1'b0;
    li_hi_c      = req_imm[31:12] + 20'(req_imm[11]);
    li_lo_word_c = {req_imm[11:0], req_rd, 3'b000, req_rd, OPC_I};
    case (req_op)
      OP_R:      enc_word_c = {1'b0, req_fn7_b5, 4'b0000, req_fn7_b0, req_rs2, req_rs1,
                               req_fn3, req_rd, OPC_R};
      OP_I: begin
        if (is_shift_c) begin
          enc_word_c = {1'b0, req_fn7_b5, 5'b00000, req_imm[4:0], req_rs1, req_fn3, req_rd, OPC_I};
        end else begin
          enc_word_c = {req_imm[11:0], req_rs1, req_fn3, req_rd, OPC_I};
        end
      end
      OP_LOAD:   enc_word_c = {req_imm[11:0], req_rs1, req_fn3, req_rd, OPC_LOAD};
      OP_STORE:  enc_word_c = {req_imm[11:5], req_rs2, req_rs1, req_fn3, req_imm[4:0], OPC_STORE};
      OP_BRANCH: enc_word_c = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_fn3,
                               req_imm[4:1], req_imm[11], OPC_BRANCH};
      OP_JALR:   enc_word_c = {req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_JALR};
      OP_JAL:    enc_word_c = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                               req_rd, OPC_JAL};
      OP_LUI:    enc_word_c = {req_imm[31:12], req_rd, OPC_LUI};
      OP_AUIPC:  enc_word_c = {req_imm[31:12], req_rd, OPC_AUIPC};
      OP_LI: begin
        if (imm_fits12_c) begin
          enc_word_c = {req_imm[11:0], 5'd0, 3'b000, req_rd, OPC_I};
        end else begin
          enc_word_c = {li_hi_c, req_rd, OPC_LUI};
          li_two_c   = |req_imm[11:0];
        end
      end
      default:   enc_word_c = NOP_WORD;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             new_err_c;

  // Immediate range legality per op class; LI is always legal
  always_comb begin
    range_err_c = 1'b0;
    case (req_op)
      OP_R, OP_LI:               range_err_c = 1'b0;
      OP_I:                      range_err_c = is_shift_c ? (|req_imm[31:5]) : !imm_fits12_c;
      OP_LOAD, OP_STORE, OP_JALR: range_err_c = !imm_fits12_c;
      OP_BRANCH:                 range_err_c = req_imm[0] ||
                                               !((&req_imm[31:12]) || !(|req_imm[31:12]));
      OP_JAL:                    range_err_c = req_imm[0] ||
                                               !((&req_imm[31:20]) || !(|req_imm[31:20]));
      OP_LUI, OP_AUIPC:          range_err_c = |req_imm[11:0];
      default:                   range_err_c = 1'b1;
    endcase
  end

  assign new_err_c = accept_c && range_err_c && (state_q == S_IDLE);

  // Sticky error and saturating counter; a new error beats a same-cycle clear
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (err_clr) begin
      err_d = new_err_c;
      cnt_d = CNT_W'(new_err_c);
    end else if (new_err_c) begin
      err_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Error state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = cnt_q;
`else
  logic unused_err_clr;

  assign range_err_c    = 1'b0;
  assign unused_err_clr = err_clr;
  assign err            = 1'b0;
  assign err_cnt        = '0;
`endif

  // Next state: push on legal acceptance, second LI word once there is room
  always_comb begin
    state_d     = state_q;
    li_word_d   = li_word_q;
    push_c      = 1'b0;
    push_word_c = enc_word_c;
    case (state_q)
      S_IDLE: begin
        if (accept_c && !range_err_c) begin
          push_c = 1'b1;
          if ((req_op == OP_LI) && li_two_c) begin
            state_d   = S_LI_LO;
            li_word_d = li_lo_word_c;
          end
        end
      end
      S_LI_LO: begin
        if (!full_q) begin
          push_c      = 1'b1;
          push_word_c = li_word_q;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping and next registered head word
  always_comb begin
    pop_c    = inst_ready && valid_q;
    count_d  = count_q + CNT_FW'(push_c) - CNT_FW'(pop_c);
    wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    full_d   = (count_d == CNT_FW'(FIFO_DEPTH));
    ready_d  = (state_d == S_IDLE) && !full_d;
    valid_d  = (count_d != '0);
    head_c   = (push_c && (wr_ptr_q == rd_ptr_d)) ? push_word_c : mem_q[rd_ptr_d];
    inst_d   = valid_d ? head_c : '0;
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      li_word_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
    end else begin
      state_q   <= state_d;
      li_word_q <= li_word_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
    end
  end

  // FIFO storage; contents are qualified by count, so no reset needed
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= push_word_c;
  end

endmodule

// File: tb/tb_ama_riscv_encoder.sv
// Directed self-checking bench for ama_riscv_encoder.
module tb_ama_riscv_encoder;

  localparam logic [3:0] OP_R = 4'd0, OP_I = 4'd1, OP_LOAD = 4'd2, OP_STORE = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4, OP_JALR = 4'd5, OP_JAL = 4'd6;
  localparam logic [3:0] OP_LUI = 4'd7, OP_AUIPC = 4'd8, OP_LI = 4'd9, OP_BAD = 4'd12;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  fn3;
    logic        b5;
    logic        b0;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [2:0]  req_fn3 = '0;
  logic        req_fn7_b5 = 1'b0;
  logic        req_fn7_b0 = 1'b0;
  logic [4:0]  req_rd = '0;
  logic [4:0]  req_rs1 = '0;
  logic [4:0]  req_rs2 = '0;
  logic [31:0] req_imm = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic        err;
  logic [7:0]  err_cnt;
  logic        err_clr = 1'b0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ama_riscv_encoder #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_fn3(req_fn3),
    .req_fn7_b5(req_fn7_b5), .req_fn7_b0(req_fn7_b0), .req_rd(req_rd), .req_rs1(req_rs1),
    .req_rs2(req_rs2), .req_imm(req_imm),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .err(err), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  // Present one request and hold it until accepted (bounded); returns #1 after the accept edge
  task automatic send(input logic [3:0] op, input logic [2:0] fn3, input logic b5, input logic b0,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    bit acc = 1'b0;
    req_op = op; req_fn3 = fn3; req_fn7_b5 = b5; req_fn7_b0 = b0;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      if (req_ready === 1'b1) acc = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    checks++;
    if (!acc) $display("FAIL send_accept op=%0d req_ready never rose within 40 cycles", op);
    else passed++;
  endtask

  // Wait (bounded) for a head word, capture it and pop it
  task automatic get_word(output logic [31:0] w);
    bit got = 1'b0;
    w = '0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (inst_valid === 1'b1) begin
        got = 1'b1;
        w = inst;
        inst_ready = 1'b1;
        @(posedge clk); #1;
        inst_ready = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!got) $display("FAIL get_word inst_valid never rose within 40 cycles");
    else passed++;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) $display("FAIL rst_ready got=%b exp=0", req_ready); else passed++;
    checks++; if (inst_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", inst_valid); else passed++;
    checks++; if (inst !== 32'h0) $display("FAIL rst_inst got=%h exp=00000000", inst); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL rst_err got=%b exp=0", err); else passed++;
    checks++; if (err_cnt !== 8'd0) $display("FAIL rst_err_cnt got=%0d exp=0", err_cnt); else passed++;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", req_ready); else passed++;
  endtask

  task automatic test_addi();
    send(OP_I, 3'd0, 1'b0, 1'b0, 5'd5, 5'd1, 5'd7, 32'hFFFF_FFFF);
    checks++; if (inst_valid !== 1'b1) $display("FAIL addi_valid got=%b exp=1", inst_valid); else passed++;
    checks++; if (inst !== 32'hFFF0_8293) $display("FAIL addi_word got=%h exp=fff08293", inst); else passed++;
    inst_ready = 1'b1;
    @(posedge clk); #1;
    inst_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0) $display("FAIL addi_drained got=%b exp=0", inst_valid); else passed++;
  endtask

  task automatic test_encodings();
    vec_t v[$];
    logic [31:0] w;
    v.push_back('{OP_R,      3'd0, 1'b1, 1'b0, 5'd3,  5'd1, 5'd2, 32'h0,          32'h4020_81B3});
    v.push_back('{OP_R,      3'd0, 1'b0, 1'b1, 5'd3,  5'd1, 5'd2, 32'h0,          32'h0220_81B3});
    v.push_back('{OP_I,      3'd5, 1'b1, 1'b0, 5'd5,  5'd6, 5'd9, 32'd3,          32'h4033_5293});
    v.push_back('{OP_LOAD,   3'd2, 1'b1, 1'b1, 5'd7,  5'd2, 5'd3, 32'hFFFF_FFF8,  32'hFF81_2383});
    v.push_back('{OP_STORE,  3'd2, 1'b0, 1'b0, 5'd9,  5'd2, 5'd5, 32'd8,          32'h0051_2423});
    v.push_back('{OP_BRANCH, 3'd0, 1'b0, 1'b0, 5'd9,  5'd1, 5'd2, 32'hFFFF_FFFC,  32'hFE20_8EE3});
    v.push_back('{OP_BRANCH, 3'd0, 1'b0, 1'b0, 5'd0,  5'd0, 5'd0, 32'd4094,       32'h7E00_0FE3});
    v.push_back('{OP_JALR,   3'd3, 1'b0, 1'b0, 5'd0,  5'd1, 5'd4, 32'd0,          32'h0000_8067});
    v.push_back('{OP_JAL,    3'd0, 1'b0, 1'b0, 5'd1,  5'd0, 5'd0, 32'd8,          32'h0080_00EF});
    v.push_back('{OP_AUIPC,  3'd0, 1'b0, 1'b0, 5'd1,  5'd0, 5'd0, 32'h0000_1000,  32'h0000_1097});
    v.push_back('{OP_LUI,    3'd0, 1'b0, 1'b0, 5'd10, 5'd3, 5'd3, 32'h1234_5000,  32'h1234_5537});
    foreach (v[i]) begin
      send(v[i].op, v[i].fn3, v[i].b5, v[i].b0, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
      get_word(w);
      checks++;
      if (w !== v[i].exp) $display("FAIL enc_vec%0d op=%0d got=%h exp=%h", i, v[i].op, w, v[i].exp);
      else passed++;
    end
  endtask

  task automatic test_li_two();
    inst_ready = 1'b1;
    send(OP_LI, 3'd0, 1'b0, 1'b0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
    checks++; if (req_ready !== 1'b0) $display("FAIL li2_ready_low got=%b exp=0", req_ready); else passed++;
    checks++; if (inst !== 32'h1234_6537) $display("FAIL li2_lui got=%h exp=12346537", inst); else passed++;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL li2_ready_back got=%b exp=1", req_ready); else passed++;
    checks++; if (inst !== 32'hFFF5_0513) $display("FAIL li2_addi got=%h exp=fff50513", inst); else passed++;
    @(posedge clk); #1;
    inst_ready = 1'b0;
    checks++; if (inst_valid !== 1'b0) $display("FAIL li2_drained got=%b exp=0", inst_valid); else passed++;
  endtask

  task automatic test_li_variants();
    logic [31:0] w;
    logic [31:0] imms [5] = '{32'd5, 32'h1234_5000, 32'd2047, 32'hFFFF_F800, 32'h0000_0800};
    logic [31:0] exp1 [5] = '{32'h0050_0513, 32'h1234_5537, 32'h7FF0_0513, 32'h8000_0513, 32'h0000_1537};
    for (int i = 0; i < 5; i++) begin
      send(OP_LI, 3'd0, 1'b0, 1'b0, 5'd10, 5'd0, 5'd0, imms[i]);
      get_word(w);
      checks++;
      if (w !== exp1[i]) $display("FAIL li_var%0d_first got=%h exp=%h", i, w, exp1[i]); else passed++;
    end
    get_word(w);
    checks++; if (w !== 32'h8005_0513) $display("FAIL li_0x800_second got=%h exp=80050513", w); else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (inst_valid !== 1'b0) $display("FAIL li_var_extra_word got=%b exp=0", inst_valid); else passed++;
  endtask

  task automatic test_errors();
`ifdef ENC_RANGE_CHECK_EN
    send(OP_BRANCH, 3'd0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
    checks++; if (inst_valid !== 1'b0) $display("FAIL beq_odd_no_word got=%b exp=0", inst_valid); else passed++;
    checks++; if (err !== 1'b1) $display("FAIL beq_odd_err got=%b exp=1", err); else passed++;
    checks++; if (err_cnt !== 8'd1) $display("FAIL beq_odd_cnt got=%0d exp=1", err_cnt); else passed++;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) $display("FAIL clr_err got=%b exp=0", err); else passed++;
    checks++; if (err_cnt !== 8'd0) $display("FAIL clr_cnt got=%0d exp=0", err_cnt); else passed++;
    send(OP_BAD, 3'd0, 1'b0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
    send(OP_BRANCH, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4096);
    checks++; if (err_cnt !== 8'd2) $display("FAIL two_err_cnt got=%0d exp=2", err_cnt); else passed++;
    checks++; if (inst_valid !== 1'b0) $display("FAIL bad_no_word got=%b exp=0", inst_valid); else passed++;
    err_clr = 1'b1;
    send(OP_BAD, 3'd0, 1'b0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
    err_clr = 1'b0;
    checks++; if (err !== 1'b1) $display("FAIL clr_vs_err_err got=%b exp=1", err); else passed++;
    checks++; if (err_cnt !== 8'd1) $display("FAIL clr_vs_err_cnt got=%0d exp=1", err_cnt); else passed++;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
`else
    logic [31:0] w;
    send(OP_BRANCH, 3'd0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
    get_word(w);
    checks++; if (w !== 32'h0020_8163) $display("FAIL beq_trunc got=%h exp=00208163", w); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL nochk_err got=%b exp=0", err); else passed++;
    send(OP_BAD, 3'd0, 1'b0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
    get_word(w);
    checks++; if (w !== 32'h0000_0013) $display("FAIL bad_nop got=%h exp=00000013", w); else passed++;
    send(OP_BRANCH, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd4096);
    get_word(w);
    checks++; if (w !== 32'h8000_0063) $display("FAIL b4096_trunc got=%h exp=80000063", w); else passed++;
    checks++; if (err_cnt !== 8'd0) $display("FAIL nochk_cnt got=%0d exp=0", err_cnt); else passed++;
`endif
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    logic [31:0] e;
    for (int i = 1; i <= 4; i++) send(OP_I, 3'd0, 1'b0, 1'b0, 5'(i), 5'd0, 5'd0, 32'(i));
    checks++; if (req_ready !== 1'b0) $display("FAIL bp_full_ready got=%b exp=0", req_ready); else passed++;
    req_op = OP_I; req_fn3 = 3'd0; req_rd = 5'd5; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 32'd5;
    req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) $display("FAIL bp_fifth_blocked got=%b exp=0", req_ready); else passed++;
    w = inst;
    inst_ready = 1'b1;
    @(posedge clk); #1;
    inst_ready = 1'b0;
    checks++; if (w !== 32'h0010_0093) $display("FAIL bp_first got=%h exp=00100093", w); else passed++;
    checks++; if (req_ready !== 1'b1) $display("FAIL bp_ready_after_pop got=%b exp=1", req_ready); else passed++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) $display("FAIL bp_refull got=%b exp=0", req_ready); else passed++;
    for (int i = 2; i <= 5; i++) begin
      get_word(w);
      e = {12'(i), 5'd0, 3'd0, 5'(i), 7'h13};
      checks++; if (w !== e) $display("FAIL bp_order%0d got=%h exp=%h", i, w, e); else passed++;
    end
  endtask

  task automatic test_reset_li_lo();
    logic [31:0] w;
    for (int i = 1; i <= 3; i++) send(OP_I, 3'd0, 1'b0, 1'b0, 5'(i), 5'd0, 5'd0, 32'(i));
    send(OP_LI, 3'd0, 1'b0, 1'b0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) $display("FAIL lilo_stall_ready got=%b exp=0", req_ready); else passed++;
    #2 rst = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) $display("FAIL lilo_rst_valid got=%b exp=0", inst_valid); else passed++;
    checks++; if (inst !== 32'h0) $display("FAIL lilo_rst_inst got=%h exp=00000000", inst); else passed++;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL lilo_idle_ready got=%b exp=1", req_ready); else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (inst_valid !== 1'b0) $display("FAIL lilo_no_stale got=%b exp=0", inst_valid); else passed++;
    send(OP_I, 3'd0, 1'b0, 1'b0, 5'd5, 5'd1, 5'd0, 32'hFFFF_FFFF);
    get_word(w);
    checks++; if (w !== 32'hFFF0_8293) $display("FAIL lilo_after got=%h exp=fff08293", w); else passed++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_encodings();
    test_li_two();
    test_li_variants();
    test_errors();
    test_backpressure();
    test_reset_li_lo();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

endmodule
